// File: rtl/apb_slave_mem.sv
// APB slave backed by an internal word memory, with programmable wait states,
// PSLVERR on misaligned/out-of-range addresses and a master protocol-violation pulse.
module apb_slave_mem #(
    parameter int unsigned APB_MAX_ADDRESS_WIDTH = 16,
    parameter int unsigned APB_MAX_DATA_WIDTH    = 32,
    parameter int unsigned MEM_DEPTH             = 256
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic                             psel,
    input  logic                             penable,
    input  logic                             pwrite,
    input  logic [APB_MAX_ADDRESS_WIDTH-1:0] paddr,
    input  logic [APB_MAX_DATA_WIDTH-1:0]    pwdata,
    input  logic [3:0]                       wait_cfg,
    output logic [APB_MAX_DATA_WIDTH-1:0]    prdata,
    output logic                             pready,
    output logic                             pslverr,
    output logic                             prot_err
);

    localparam int unsigned AW = APB_MAX_ADDRESS_WIDTH;
    localparam int unsigned DW = APB_MAX_DATA_WIDTH;
    localparam int unsigned IW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] DEPTH_A = AW'(MEM_DEPTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            err_q;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   mem [MEM_DEPTH];

    logic            range_err;
    logic            mismatch;
    logic            done;
    logic [IW-1:0]   idx;

    always_comb begin
        range_err = (paddr[1:0] != 2'b00) || ((paddr >> 2) >= DEPTH_A);
        mismatch  = (paddr != addr_q) || (pwrite != wr_q) || (pwdata != wdata_q);
        idx       = addr_q[IW+1:2];
        done      = (state == ACCESS) && psel && penable && (cnt == '0);
        pready    = done;
        pslverr   = done && err_q;
        prdata    = (done && !err_q && !wr_q) ? mem[idx] : '0;
    end

    // Completion always uses the setup-phase address/data; access-phase drift only raises prot_err.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            cnt      <= '0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            prot_err <= 1'b0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            prot_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state   <= ACCESS;
                        cnt     <= wait_cfg;
                        err_q   <= range_err;
                        wr_q    <= pwrite;
                        addr_q  <= paddr;
                        wdata_q <= pwdata;
                    end else if (psel && penable) begin
                        prot_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!psel || !penable) begin
                        state    <= IDLE;
                        prot_err <= 1'b1;
                    end else begin
                        if (mismatch) begin
                            prot_err <= 1'b1;
                        end
                        if (cnt == '0) begin
                            state <= IDLE;
                            if (wr_q && !err_q) begin
                                mem[idx] <= wdata_q;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
